// File: rtl/rv32_wb_pkg.sv
// Shared types and helpers for the RV32I writeback path.
// Contents: load funct3 encodings, the writeback queue entry, and the
// load-data formatter (byte/halfword select plus sign/zero extension).
package rv32_wb_pkg;

    localparam int unsigned WB_XLEN = 32;
    localparam int unsigned REG_AW  = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [REG_AW-1:0]  rd;
        logic [WB_XLEN-1:0] data;
        logic               is_load;
    } wb_entry_t;

    localparam int unsigned WB_ENTRY_W = $bits(wb_entry_t);

    // Extract the addressed byte/halfword from an aligned word and extend it.
    // Unknown funct3 encodings fall back to a full-word load.
    function automatic logic [WB_XLEN-1:0] fmt_load(
        input logic [2:0]         funct3,
        input logic [1:0]         addr_lo,
        input logic [WB_XLEN-1:0] rdata
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (addr_lo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   fmt_load = {{24{b[7]}}, b};
            F3_LBU:  fmt_load = {24'd0, b};
            F3_LH:   fmt_load = {{16{h[15]}}, h};
            F3_LHU:  fmt_load = {16'd0, h};
            default: fmt_load = rdata;
        endcase
    endfunction

endpackage

// File: rtl/rf_writeback_seq_wb_fifo.sv
// wb_fifo: circular buffer for writeback entries.
// Read/write pointers carry one extra wrap bit so full and empty are
// distinguishable with equal index bits. Flags are registered and follow
// occupancy at the push/pop edge.
// Ports: clk, rst (async, active-high), push/wdata (enqueue), pop/rdata
// (dequeue, rdata = current head), full, empty.
module wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         full_q, full_d;
    logic         empty_q, empty_d;
    logic         do_push, do_pop;

    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign do_push = push && (!full_q || pop);
    assign do_pop  = pop && !empty_q;

    // Next pointers, storage and flags.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q[AW-1:0]];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/rf_writeback_seq.sv
// rf_writeback_seq: writeback sequencer for the RV32I register bank.
// Accepts one ALU result or load response per cycle (loads win), formats
// load data, queues entries and drains the head onto the single register
// bank write port, one registered write per cycle. Keeps a pending-load
// scoreboard (busy_mask) for issue stalls.
// Ports:
//   clk, rst (async, active-high)
//   alu_valid/alu_ready/alu_rd/alu_data        ALU result handshake
//   ld_issue/ld_issue_rd                       load issued (scoreboard set)
//   ld_valid/ld_ready/ld_rd/ld_funct3/
//   ld_addr_lo/ld_rdata                        load response handshake
//   rf_we/rf_rd/rf_data                        register bank write port
//   busy_mask                                  registers awaiting load data
//   q_full/q_empty                             queue occupancy flags
// Optional: define RF_WB_FWD_EN to add fwd_valid/fwd_rd/fwd_data, a bypass
// copy of the write port for readers in the write cycle.
module rf_writeback_seq
    import rv32_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_issue,
    input  logic [4:0]      ld_issue_rd,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic [XLEN-1:0] ld_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_data,
    output logic [31:0]     busy_mask,
    output logic            q_full,
    output logic            q_empty
`ifdef RF_WB_FWD_EN
    ,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
`endif
);

    wb_entry_t              enq_entry;
    wb_entry_t              head;
    logic [WB_ENTRY_W-1:0]  head_bits;
    logic                   push;
    logic                   pop;

    logic                   rf_we_q, rf_we_d;
    logic [4:0]             rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]        rf_data_q, rf_data_d;
    logic [31:0]            busy_q, busy_d;

    // Load responses have priority over ALU results for the single enqueue slot.
    assign ld_ready  = !q_full;
    assign alu_ready = !q_full && !ld_valid;

    // Build the enqueue entry; x0 destinations are accepted but dropped.
    always_comb begin
        enq_entry = '0;
        push      = 1'b0;
        if (ld_valid && ld_ready) begin
            enq_entry.rd      = ld_rd;
            enq_entry.data    = fmt_load(ld_funct3, ld_addr_lo, ld_rdata);
            enq_entry.is_load = 1'b1;
            push              = (ld_rd != 5'd0);
        end else if (alu_valid && alu_ready) begin
            enq_entry.rd      = alu_rd;
            enq_entry.data    = alu_data;
            enq_entry.is_load = 1'b0;
            push              = (alu_rd != 5'd0);
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (WB_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (enq_entry),
        .rdata (head_bits),
        .full  (q_full),
        .empty (q_empty)
    );

    assign head = head_bits;
    assign pop  = !q_empty;

    // Write port and scoreboard next state; a same-cycle issue beats the clear.
    always_comb begin
        rf_we_d   = pop;
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;
        busy_d    = busy_q;
        if (pop) begin
            rf_rd_d   = head.rd;
            rf_data_d = head.data;
            if (head.is_load) begin
                busy_d[head.rd] = 1'b0;
            end
        end
        if (ld_issue && (ld_issue_rd != 5'd0)) begin
            busy_d[ld_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Output and scoreboard registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
            busy_q    <= '0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
            busy_q    <= busy_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_rd     = rf_rd_q;
    assign rf_data   = rf_data_q;
    assign busy_mask = busy_q;

`ifdef RF_WB_FWD_EN
    assign fwd_valid = rf_we_q;
    assign fwd_rd    = rf_rd_q;
    assign fwd_data  = rf_data_q;
`endif

endmodule

// File: tb/tb_rf_writeback_seq.sv
// Self-checking bench for rf_writeback_seq: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a queue-based
// reference model of the writeback behaviour.
module tb_rf_writeback_seq;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic [31:0] ld_rdata;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic [31:0] busy_mask;
    logic        q_full;
    logic        q_empty;
`ifdef RF_WB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    rf_writeback_seq #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_funct3   (ld_funct3),
        .ld_addr_lo  (ld_addr_lo),
        .ld_rdata    (ld_rdata),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_data     (rf_data),
        .busy_mask   (busy_mask),
        .q_full      (q_full),
        .q_empty     (q_empty)
`ifdef RF_WB_FWD_EN
        ,
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state: pending writes in arrival order plus the
    // expected write-port and scoreboard contents.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          ld;
    } ment_t;

    ment_t       mq[$];
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [31:0] m_busy;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Load formatting expressed arithmetically on the raw word.
    function automatic logic [31:0] ref_fmt(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * lo)) & 32'h0000_00FF;
        h = (w >> (lo[1] ? 16 : 0)) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_we   = 1'b0;
        m_rd   = '0;
        m_data = '0;
        m_busy = '0;
    endtask

    task automatic drive_idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_issue = 1'b0; ld_issue_rd = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_addr_lo = '0; ld_rdata = '0;
    endtask

    // One clock cycle: drive, check readies, advance model, check outputs.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic li, input logic [4:0] lird,
                        input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                        input logic [1:0] lo, input logic [31:0] rdat);
        ment_t e;
        logic  mfull;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        ld_issue = li; ld_issue_rd = lird;
        ld_valid = lv; ld_rd = lrd; ld_funct3 = f3; ld_addr_lo = lo; ld_rdata = rdat;
        #1;
        mfull = (mq.size() == DEPTH);
        chk("ld_ready", 32'(ld_ready), 32'(!mfull));
        chk("alu_ready", 32'(alu_ready), 32'(!mfull && !lv));
        if (mq.size() > 0) begin
            e      = mq.pop_front();
            m_we   = 1'b1;
            m_rd   = e.rd;
            m_data = e.data;
            if (e.ld) m_busy[e.rd] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (lv && !mfull) begin
            if (lrd != 5'd0) mq.push_back('{rd: lrd, data: ref_fmt(f3, lo, rdat), ld: 1'b1});
        end else if (av && !mfull) begin
            if (ard != 5'd0) mq.push_back('{rd: ard, data: ad, ld: 1'b0});
        end
        if (li && lird != 5'd0) m_busy[lird] = 1'b1;
        @(posedge clk);
        #1;
        chk("rf_we", 32'(rf_we), 32'(m_we));
        chk("rf_rd", 32'(rf_rd), 32'(m_rd));
        chk("rf_data", rf_data, m_data);
        chk("busy_mask", busy_mask, m_busy);
        chk("q_empty", 32'(q_empty), 32'(mq.size() == 0));
        chk("q_full", 32'(q_full), 32'(mq.size() == DEPTH));
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        step(1'b1, rd, d, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    endtask

    task automatic ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                      input logic [31:0] w);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, rd, f3, lo, w);
    endtask

    task automatic issue(input logic [4:0] rd);
        step(1'b0, 5'd0, 32'd0, 1'b1, rd, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        model_reset();
        #12;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_rd", 32'(rf_rd), 32'd0);
        chk("rst_rf_data", rf_data, 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_q_empty", 32'(q_empty), 32'd1);
        chk("rst_q_full", 32'(q_full), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        rst = 1'b0;

        // ALU write latency: accepted at edge k, visible after edge k+1.
        alu(5'd5, 32'h0000_1234);
        chk("lat_no_we_yet", 32'(rf_we), 32'd0);
        idle();
        chk("lat_we", 32'(rf_we), 32'd1);
        chk("lat_rd", 32'(rf_rd), 32'd5);
        chk("lat_data", rf_data, 32'h0000_1234);
        idle();
        chk("lat_we_drop", 32'(rf_we), 32'd0);
        chk("lat_hold_data", rf_data, 32'h0000_1234);

        // Load formatting.
        ld(5'd7, 3'b000, 2'd3, 32'h80FF_0000);
        idle();
        chk("lb_data", rf_data, 32'hFFFF_FF80);
        ld(5'd7, 3'b101, 2'd2, 32'h80FF_0000);
        idle();
        chk("lhu_data", rf_data, 32'h0000_80FF);
        ld(5'd8, 3'b001, 2'd3, 32'h8001_7F00);
        idle();
        chk("lh_data", rf_data, 32'hFFFF_8001);
        ld(5'd8, 3'b111, 2'd1, 32'hDEAD_BEEF);
        idle();
        chk("lw_fallback", rf_data, 32'hDEAD_BEEF);

        // Simultaneous offers: load first, ALU next cycle, writes in that order.
        step(1'b1, 5'd4, 32'hAAAA_0004, 1'b0, 5'd0, 1'b1, 5'd3, 3'b010, 2'd0, 32'h3333_0003);
        alu(5'd4, 32'hAAAA_0004);
        chk("prio_first_rd", 32'(rf_rd), 32'd3);
        idle();
        chk("prio_second_rd", 32'(rf_rd), 32'd4);
        chk("prio_second_data", rf_data, 32'hAAAA_0004);
        idle();

        // Scoreboard: set, clear on writeback, and set winning over clear.
        issue(5'd9);
        chk("sb_set", busy_mask, 32'h0000_0200);
        ld(5'd9, 3'b010, 2'd0, 32'h0000_0099);
        chk("sb_still_set", busy_mask, 32'h0000_0200);
        idle();
        chk("sb_clear_we", 32'(rf_we), 32'd1);
        chk("sb_cleared", busy_mask, 32'd0);
        issue(5'd9);
        ld(5'd9, 3'b010, 2'd0, 32'h0000_0199);
        issue(5'd9);
        chk("sb_set_wins", busy_mask, 32'h0000_0200);
        ld(5'd9, 3'b010, 2'd0, 32'h0000_0299);
        idle();
        chk("sb_final_clear", busy_mask, 32'd0);
        issue(5'd0);
        chk("sb_x0_ignored", busy_mask, 32'd0);

        // Writes to x0 are swallowed.
        alu(5'd0, 32'hFFFF_FFFF);
        idle();
        chk("x0_no_we", 32'(rf_we), 32'd0);
        ld(5'd0, 3'b010, 2'd0, 32'h1234_5678);
        idle();
        chk("x0_ld_no_we", 32'(rf_we), 32'd0);

        // Back-to-back traffic sustains one write per cycle.
        for (int i = 1; i <= 16; i++) begin
            alu(5'(i), 32'h1000_0000 + 32'(i));
        end
        idle();
        chk("b2b_last", rf_data, 32'h1000_0010);
        idle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom());
        end

        // Asynchronous reset mid-operation with a write in flight.
        issue(5'd12);
        alu(5'd5, 32'h5555_0005);
        alu(5'd6, 32'h6666_0006);
        chk("pre_rst_we", 32'(rf_we), 32'd1);
        #2;
        rst = 1'b1;
        drive_idle();
        #1;
        chk("arst_we", 32'(rf_we), 32'd0);
        chk("arst_busy", busy_mask, 32'd0);
        chk("arst_q_empty", 32'(q_empty), 32'd1);
        chk("arst_rf_data", rf_data, 32'd0);
        model_reset();
        #1;
        rst = 1'b0;
        idle();
        chk("post_rst_no_we", 32'(rf_we), 32'd0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
